// File: rtl/aes_pkg.sv
// Shared AES definitions: controller states, block width, round counts per
// key size and GF(2^8) helpers used by the inverse-cipher datapath.
package aes_pkg;

  localparam int BLOCK_W   = 128;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} state_t;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] s;
    s = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(s);
  endfunction

endpackage

// File: rtl/aes_dec_last_round.sv
// Final inverse round: same as a full round but without InvMixColumns.
module aes_dec_last_round (
  input  logic [127:0] din,
  input  logic [127:0] rk,
  output logic [127:0] dout
);

  logic [127:0] shifted;
  logic [127:0] subbed;

  unshift_rows u_unshift (.din(din),     .dout(shifted));
  byte_sub     u_sub     (.din(shifted), .dout(subbed));

  assign dout = subbed ^ rk;

endmodule

// File: rtl/byte_sub.sv
// Inverse SubBytes over a full 128-bit state.
module byte_sub
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dout[8*i +: 8] = inv_sbox(din[8*i +: 8]);
  end

endmodule

// File: rtl/round_uneval.sv
// One full inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module round_uneval
  import aes_pkg::*;
(
  input  logic [127:0] din,
  input  logic [127:0] rk,
  output logic [127:0] dout
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  unshift_rows u_unshift (.din(din),     .dout(shifted));
  byte_sub     u_sub     (.din(shifted), .dout(subbed));

  assign keyed = subbed ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign dout[127-32*c -: 32] = inv_mix_col(keyed[127-32*c -: 32]);
  end

endmodule

// File: rtl/unshift_rows.sv
// Inverse ShiftRows: row r rotates right by r bytes. Byte k of the block
// (MSB first) sits at row k%4, column k/4.
module unshift_rows (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dout[127-8*(4*c+r) -: 8] = din[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/aes_dec_ctrl.sv
// Iterative AES inverse-cipher controller: one block in flight, stepping the
// single-round datapath over NR rounds with round keys fetched by index.
module aes_dec_ctrl
  import aes_pkg::*;
#(
  parameter int NR   = 10,
  parameter int RK_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic [RK_W-1:0]    rk_idx,
  input  logic [127:0]       rk_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               busy
);

  state_t             state;
  state_t             state_nx;
  logic [RK_W-1:0]    ctr;
  logic [BLOCK_W-1:0] st;
  logic [BLOCK_W-1:0] st_round;
  logic [BLOCK_W-1:0] st_last;
  logic [BLOCK_W-1:0] st_step;

  round_uneval       u_round (.din(st), .rk(rk_data), .dout(st_round));
  aes_dec_last_round u_last  (.din(st), .rk(rk_data), .dout(st_last));

  // Only the final round skips InvMixColumns, so one select covers both.
  assign st_step  = (state == LAST) ? st_last : st_round;
  assign out_data = st;

  // Next-state and handshake/key-index decode from registered state only.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    rk_idx    = ctr;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        rk_idx   = RK_W'(NR);
        if (in_valid) state_nx = ROUND;
      end
      ROUND: begin
        rk_idx = ctr;
        if (ctr == RK_W'(1)) state_nx = LAST;
      end
      LAST: begin
        rk_idx   = '0;
        state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and round counter; counter only reloads in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ctr   <= RK_W'(NR - 1);
    end else begin
      state <= state_nx;
      case (state)
        IDLE:    ctr <= RK_W'(NR - 1);
        ROUND:   ctr <= ctr - 1'b1;
        default: ;
      endcase
    end
  end

  // Cipher state: initial AddRoundKey on accept, one round per cycle after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= '0;
    end else begin
      case (state)
        IDLE:        if (in_valid) st <= in_data ^ rk_data;
        ROUND, LAST: st <= st_step;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: known-answer table, multi-cycle corner cases and a
// randomized regression against a forward AES-128 model with a scoreboard.
`timescale 1ns/1ps
module tb_aes_dec_ctrl;

  localparam int NR    = 10;
  localparam int RK_W  = 4;
  localparam int NRAND = 1000;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    in_data;
  logic [RK_W-1:0] rk_idx;
  logic [127:0]    rk_data;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    out_data;
  logic            busy;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int cyc = 0;
  bit drv_done;

  logic [127:0] sbq [$];
  logic [7:0]   sbox [256];
  logic [127:0] ks [16];
  vec_t         vecs [4];

  aes_dec_ctrl #(.NR(NR), .RK_W(RK_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key store model: combinational same-cycle return.
  assign rk_data = ks[rk_idx];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: every output handshake pops the oldest expected plaintext.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_out++;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: got %h, required no output", out_data);
      end else begin
        check("out_data", out_data, sbq.pop_front());
      end
    end
  end

  // Forward S-box via the generator walk (p times 3, q times 1/3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // AES-128 key expansion into the key-store model.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher using the currently loaded key schedule.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ ks[0][127-8*k -: 8];
    for (int rnd = 1; rnd <= NR; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox[s[k]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (rnd < NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ ks[rnd][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns at the negedge before the accepting edge (in_valid already high).
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, required 1");
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: busy stayed 1 for 500 cycles, required 0");
    end
  endtask

  // One table transaction with out_ready held high: trace, latency, handshake.
  task automatic run_block(input int v);
    bit ok;
    int lat;
    expand(vecs[v].key);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = vecs[v].ct;
    wait_accept(ok);
    if (ok) begin
      sbq.push_back(vecs[v].pt);
      check("acc_rk_idx", rk_idx, 128'(NR));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (out_valid) begin lat = k; break; end
        check("rk_idx_trace", rk_idx, 128'(NR - k));
        check("busy_trace", busy, 128'd1);
        check("in_ready_trace", in_ready, 128'd0);
      end
      check("latency", 128'(lat), 128'(NR + 1));
      @(posedge clk); #1;
      @(negedge clk);
      check("post_in_ready", in_ready, 128'd1);
      check("post_busy", busy, 128'd0);
    end
  endtask

  initial begin
    logic [127:0] key, pt, ct;
    bit ok;
    int acc [$];
    int n_out0;

    drv_done = 1'b0;
    for (int i = 0; i < 16; i++) ks[i] = '0;
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};
    build_sbox();

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_in_ready", in_ready, 128'd1);
    check("rst_out_valid", out_valid, 128'd0);
    check("rst_busy", busy, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_rk_idx", rk_idx, 128'(NR));

    // Known-answer table
    for (int v = 0; v < 4; v++) run_block(v);

    // Backpressure: hold DONE for 20 cycles while in_valid pulses
    expand(vecs[0].key);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = vecs[0].ct;
    wait_accept(ok);
    if (ok) sbq.push_back(vecs[0].pt);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      in_valid = k[0];
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("bp_out_valid", out_valid, 128'd1);
      check("bp_out_data", out_data, vecs[0].pt);
      check("bp_in_ready", in_ready, 128'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_rel_in_ready", in_ready, 128'd1);
    check("bp_rel_busy", busy, 128'd0);
    check("bp_rel_out_valid", out_valid, 128'd0);
    repeat (12) @(negedge clk);
    check("bp_no_capture", busy, 128'd0);

    // Back-to-back with in_valid held high
    expand(vecs[0].key);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = vecs[0].ct; out_ready = 1'b1;
    for (int k = 0; k < 60 && acc.size() < 2; k++) begin
      @(negedge clk);
      if (in_ready) begin acc.push_back(cyc); sbq.push_back(vecs[0].pt); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(acc.size()), 128'd2);
    if (acc.size() == 2) check("b2b_spacing", 128'(acc[1] - acc[0]), 128'(NR + 2));
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) break;
    end
    check("b2b_drain", 128'(sbq.size()), 128'd0);

    // Reset during ROUND at ctr=5
    expand(vecs[0].key);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = vecs[0].ct; out_ready = 1'b1;
    wait_accept(ok);
    @(posedge clk); #1 in_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy && rk_idx == 4'd5) begin ok = 1'b1; break; end
    end
    check("mid_reach_ctr5", 128'(ok), 128'd1);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_out_valid", out_valid, 128'd0);
    check("mid_in_ready", in_ready, 128'd1);
    check("mid_rk_idx", rk_idx, 128'(NR));
    check("mid_busy", busy, 128'd0);
    check("mid_out_data", out_data, 128'd0);
    run_block(1);

    // Random regression with input gaps and output stalls
    n_out0 = n_out;
    fork
      begin
        while (!drv_done) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int b = 0; b < NRAND; b++) begin
          key = {$urandom, $urandom, $urandom, $urandom};
          pt  = {$urandom, $urandom, $urandom, $urandom};
          expand(key);
          ct = encrypt(pt);
          repeat ($urandom_range(0, 3) + 1) @(posedge clk);
          #1;
          in_valid = 1'b1; in_data = ct;
          wait_accept(ok);
          if (!ok) break;
          sbq.push_back(pt);
          @(posedge clk); #1;
          in_valid = 1'b0;
          in_data  = {$urandom, $urandom, $urandom, $urandom};
          wait_idle(ok);
          if (!ok) break;
        end
        drv_done = 1'b1;
      end
    join
    @(posedge clk); #1 out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) break;
    end
    check("rand_drain", 128'(sbq.size()), 128'd0);
    check("rand_count", 128'(n_out - n_out0), 128'(NRAND));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
